m20k_dual_port_arbiter: RTL and testbench

- Shares one bidirectional dual-port 8192x2 M20K macro (ports 0 and 1, common clock) between NUM_REQ independent requesters.
- Each cycle, a round-robin scheduler grants up to two requests, one per memory port.
- Blocks same-address hazards: write/write and read/write on the same word in the same cycle.
- Routes read data back to the originating requester one cycle after grant. Sits between client logic and the memory wrapper.

---
 rtl/m20k_dual_port_arbiter.sv | 123 ++++++++++++
 tb/tb_m20k_dual_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/m20k_dual_port_arbiter.sv
// Round-robin arbiter sharing one dual-port 8192x2 M20K between NUM_REQ requesters.
// It grants up to two hazard-free requests per cycle and routes the read data back to each requester.
module m20k_dual_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int AW      = 13,
  parameter int DW      = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NUM_REQ-1:0]    REQ_VALID,
  input  logic [NUM_REQ-1:0]    REQ_WE,
  input  logic [NUM_REQ*AW-1:0] REQ_ADDR,
  input  logic [NUM_REQ*DW-1:0] REQ_WDATA,
  output logic [NUM_REQ-1:0]    REQ_READY,
  output logic [NUM_REQ-1:0]    RSP_VALID,
  output logic [NUM_REQ*DW-1:0] RSP_DATA,
  output logic [AW-1:0]         A0,
  output logic [AW-1:0]         A1,
  output logic [DW-1:0]         D0,
  output logic [DW-1:0]         D1,
  output logic                  CE0,
  output logic                  CE1,
  output logic                  WE0,
  output logic                  WE1,
  input  logic [DW-1:0]         Q0,
  input  logic [DW-1:0]         Q1
);

  localparam int PW = $clog2(NUM_REQ);
  typedef logic [PW-1:0] idx_t;

  idx_t rrPtr_q, rrPtr_d;
  logic rdPend0Valid_q, rdPend0Valid_d;
  logic rdPend1Valid_q, rdPend1Valid_d;
  idx_t rdPend0Idx_q, rdPend0Idx_d;
  idx_t rdPend1Idx_q, rdPend1Idx_d;

  logic g0Valid, g1Valid;
  idx_t g0Idx, g1Idx, cand, lastIdx;

  // A candidate that hits port 0's word while either side writes is skipped, so scanning continues past it.
  always_comb begin
    g0Valid = 1'b0;
    g1Valid = 1'b0;
    g0Idx   = '0;
    g1Idx   = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = idx_t'((int'(rrPtr_q) + k) % NUM_REQ);
      if (!RST && REQ_VALID[cand]) begin
        if (!g0Valid) begin
          g0Valid = 1'b1;
          g0Idx   = cand;
        end else if (!g1Valid &&
                     !((REQ_ADDR[cand*AW +: AW] == REQ_ADDR[g0Idx*AW +: AW]) &&
                       (REQ_WE[cand] || REQ_WE[g0Idx]))) begin
          g1Valid = 1'b1;
          g1Idx   = cand;
        end
      end
    end
  end

  always_comb begin
    REQ_READY = '0;
    if (g0Valid) REQ_READY[g0Idx] = 1'b1;
    if (g1Valid) REQ_READY[g1Idx] = 1'b1;
  end

  always_comb begin
    CE0 = g0Valid;
    WE0 = g0Valid && REQ_WE[g0Idx];
    A0  = g0Valid ? REQ_ADDR[g0Idx*AW +: AW] : '0;
    D0  = g0Valid ? REQ_WDATA[g0Idx*DW +: DW] : '0;
    CE1 = g1Valid;
    WE1 = g1Valid && REQ_WE[g1Idx];
    A1  = g1Valid ? REQ_ADDR[g1Idx*AW +: AW] : '0;
    D1  = g1Valid ? REQ_WDATA[g1Idx*DW +: DW] : '0;
  end

  always_comb begin
    lastIdx = g1Valid ? g1Idx : g0Idx;
    rrPtr_d = rrPtr_q;
    if (g0Valid) begin
      rrPtr_d = (lastIdx == idx_t'(NUM_REQ - 1)) ? '0 : lastIdx + 1'b1;
    end
    rdPend0Valid_d = g0Valid && !REQ_WE[g0Idx];
    rdPend0Idx_d   = g0Idx;
    rdPend1Valid_d = g1Valid && !REQ_WE[g1Idx];
    rdPend1Idx_d   = g1Idx;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rrPtr_q        <= '0;
      rdPend0Valid_q <= 1'b0;
      rdPend1Valid_q <= 1'b0;
      rdPend0Idx_q   <= '0;
      rdPend1Idx_q   <= '0;
    end else begin
      rrPtr_q        <= rrPtr_d;
      rdPend0Valid_q <= rdPend0Valid_d;
      rdPend1Valid_q <= rdPend1Valid_d;
      rdPend0Idx_q   <= rdPend0Idx_d;
      rdPend1Idx_q   <= rdPend1Idx_d;
    end
  end

  // Memory Q is already one cycle behind the grant, so it is steered straight to the owning lane.
  always_comb begin
    RSP_VALID = '0;
    RSP_DATA  = '0;
    if (rdPend0Valid_q) begin
      RSP_VALID[rdPend0Idx_q]            = 1'b1;
      RSP_DATA[rdPend0Idx_q*DW +: DW]    = Q0;
    end
    if (rdPend1Valid_q) begin
      RSP_VALID[rdPend1Idx_q]            = 1'b1;
      RSP_DATA[rdPend1Idx_q*DW +: DW]    = Q1;
    end
  end

endmodule

// File: tb/tb_m20k_dual_port_arbiter.sv
// Bench for m20k_dual_port_arbiter: vector table, hand sequences and random traffic.
// Results are compared against a queue-based scheduling model and a shadow memory.
module tb_m20k_dual_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 13;
  localparam int DW = 2;

  logic            CLK, RST;
  logic [N-1:0]    REQ_VALID, REQ_WE, REQ_READY, RSP_VALID;
  logic [N*AW-1:0] REQ_ADDR;
  logic [N*DW-1:0] REQ_WDATA, RSP_DATA;
  logic [AW-1:0]   A0, A1;
  logic [DW-1:0]   D0, D1, Q0, Q1;
  logic            CE0, CE1, WE0, WE1;

  m20k_dual_port_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_WE(REQ_WE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_READY(REQ_READY),
    .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA),
    .A0(A0), .A1(A1), .D0(D0), .D1(D1), .CE0(CE0), .CE1(CE1),
    .WE0(WE0), .WE1(WE1), .Q0(Q0), .Q1(Q1)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Stand-in for the M20K: synchronous read, output held between reads.
  logic [DW-1:0] benchMem [0:8191];
  initial begin
    for (int i = 0; i < 8192; i++) benchMem[i] = '0;
    Q0 = '0;
    Q1 = '0;
  end
  always @(posedge CLK) begin
    if (CE0) begin
      if (WE0) benchMem[A0] <= D0;
      else     Q0 <= benchMem[A0];
    end
    if (CE1) begin
      if (WE1) benchMem[A1] <= D1;
      else     Q1 <= benchMem[A1];
    end
  end

  int nCompared = 0;
  int nMismatch = 0;

  logic [DW-1:0] refMem [0:8191];
  int            mPtr;
  bit            pV [2];
  int            pI [2];
  logic [DW-1:0] pD [2];
  logic [N-1:0]  lastGrant;

  typedef struct {
    logic            rst;
    logic [N-1:0]    valid;
    logic [N-1:0]    we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    expReady;
    logic [N-1:0]    expRspV;
    logic [N*DW-1:0] expRspD;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mkVec(input logic rst, input logic [3:0] v, w,
                                 input logic [12:0] a3, a2, a1, a0,
                                 input logic [7:0] wd, input logic [3:0] er, ev,
                                 input logic [7:0] ed);
    vec_t r;
    r.rst = rst; r.valid = v; r.we = w; r.addr = {a3, a2, a1, a0};
    r.wdata = wd; r.expReady = er; r.expRspV = ev; r.expRspD = ed;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic void modelGrants(input logic [N-1:0] v, w, input logic [N*AW-1:0] a,
                                      input int ptr, output bit g0v, output int g0,
                                      output bit g1v, output int g1);
    int order[$];
    int c;
    g0v = 0; g1v = 0; g0 = 0; g1 = 0;
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) order.push_back((ptr + k) % N);
    if (order.size() > 0) begin
      g0v = 1;
      g0  = order[0];
      for (int j = 1; j < order.size(); j++) begin
        c = order[j];
        if (!g1v && !(a[c*AW +: AW] == a[g0*AW +: AW] && (w[c] || w[g0]))) begin
          g1v = 1;
          g1  = c;
        end
      end
    end
  endfunction

  task automatic setReq(input int i, input logic v, input logic w,
                        input logic [12:0] a, input logic [1:0] d);
    REQ_VALID[i]          = v;
    REQ_WE[i]             = w;
    REQ_ADDR[i*AW +: AW]  = a;
    REQ_WDATA[i*DW +: DW] = d;
  endtask

  // Applies the already-driven inputs for one cycle, checks, then advances the model past the edge.
  task automatic applyStimulus(input bit useTab, input logic [N-1:0] tReady, tRspV,
                               input logic [N*DW-1:0] tRspD);
    bit g0v, g1v;
    int g0, g1;
    logic [N-1:0]    eReady, eRspV;
    logic [N*DW-1:0] eRspD;
    bit nV [2];
    int nI [2];
    logic [DW-1:0] nD [2];
    #2;
    if (RST) begin
      mPtr = 0;
      pV[0] = 0;
      pV[1] = 0;
      g0v = 0; g1v = 0; g0 = 0; g1 = 0;
    end else begin
      modelGrants(REQ_VALID, REQ_WE, REQ_ADDR, mPtr, g0v, g0, g1v, g1);
    end
    eReady = '0;
    if (g0v) eReady[g0] = 1'b1;
    if (g1v) eReady[g1] = 1'b1;
    eRspV = '0;
    eRspD = '0;
    for (int p = 0; p < 2; p++) begin
      if (pV[p]) begin
        eRspV[pI[p]] = 1'b1;
        eRspD[pI[p]*DW +: DW] = pD[p];
      end
    end
    checkOutput("REQ_READY", REQ_READY, eReady);
    checkOutput("CE0", CE0, g0v);
    checkOutput("WE0", WE0, g0v && REQ_WE[g0]);
    checkOutput("A0",  A0,  g0v ? REQ_ADDR[g0*AW +: AW] : 13'd0);
    checkOutput("D0",  D0,  g0v ? REQ_WDATA[g0*DW +: DW] : 2'd0);
    checkOutput("CE1", CE1, g1v);
    checkOutput("WE1", WE1, g1v && REQ_WE[g1]);
    checkOutput("A1",  A1,  g1v ? REQ_ADDR[g1*AW +: AW] : 13'd0);
    checkOutput("D1",  D1,  g1v ? REQ_WDATA[g1*DW +: DW] : 2'd0);
    checkOutput("RSP_VALID", RSP_VALID, eRspV);
    checkOutput("RSP_DATA",  RSP_DATA,  eRspD);
    if (useTab) begin
      checkOutput("tab_READY", REQ_READY, tReady);
      checkOutput("tab_RSP_VALID", RSP_VALID, tRspV);
      checkOutput("tab_RSP_DATA", RSP_DATA, tRspD);
    end
    lastGrant = eReady;
    nV[0] = g0v && !REQ_WE[g0]; nI[0] = g0; nD[0] = refMem[REQ_ADDR[g0*AW +: AW]];
    nV[1] = g1v && !REQ_WE[g1]; nI[1] = g1; nD[1] = refMem[REQ_ADDR[g1*AW +: AW]];
    if (g0v && REQ_WE[g0]) refMem[REQ_ADDR[g0*AW +: AW]] = REQ_WDATA[g0*DW +: DW];
    if (g1v && REQ_WE[g1]) refMem[REQ_ADDR[g1*AW +: AW]] = REQ_WDATA[g1*DW +: DW];
    if (g1v)      mPtr = (g1 + 1) % N;
    else if (g0v) mPtr = (g0 + 1) % N;
    @(posedge CLK);
    #1;
    for (int p = 0; p < 2; p++) begin
      pV[p] = nV[p];
      pI[p] = nI[p];
      pD[p] = nD[p];
    end
  endtask

  initial begin
    int sel;
    for (int i = 0; i < 8192; i++) refMem[i] = '0;
    mPtr = 0;
    pV[0] = 0; pV[1] = 0;
    pI[0] = 0; pI[1] = 0;
    pD[0] = '0; pD[1] = '0;
    RST = 1'b1;
    REQ_VALID = '0; REQ_WE = '0; REQ_ADDR = '0; REQ_WDATA = '0;

    tab.push_back(mkVec(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 8'h00, 4'b0000, 4'b0000, 8'h00));
    tab.push_back(mkVec(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 8'h00, 4'b0000, 4'b0000, 8'h00));
    for (int i = 0; i < 10; i++)
      tab.push_back(mkVec(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 8'h00, 4'b0000, 4'b0000, 8'h00));
    tab.push_back(mkVec(0, 4'b0001, 4'b0001, 0, 0, 0, 13'h0005, 8'h02, 4'b0001, 4'b0000, 8'h00));
    tab.push_back(mkVec(0, 4'b0100, 4'b0000, 0, 13'h0005, 0, 0, 8'h00, 4'b0100, 4'b0000, 8'h00));
    tab.push_back(mkVec(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 8'h00, 4'b0000, 4'b0100, 8'h20));
    tab.push_back(mkVec(0, 4'b0001, 4'b0000, 0, 0, 0, 13'h0000, 8'h00, 4'b0001, 4'b0000, 8'h00));
    tab.push_back(mkVec(0, 4'b0110, 4'b0010, 0, 13'h1FFF, 13'h1FFF, 0, 8'h0C, 4'b0010, 4'b0001, 8'h00));
    tab.push_back(mkVec(0, 4'b0100, 4'b0000, 0, 13'h1FFF, 0, 0, 8'h00, 4'b0100, 4'b0000, 8'h00));
    tab.push_back(mkVec(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 8'h00, 4'b0000, 4'b0100, 8'h30));
    tab.push_back(mkVec(0, 4'b0010, 4'b0010, 0, 0, 13'h0100, 0, 8'h04, 4'b0010, 4'b0000, 8'h00));
    tab.push_back(mkVec(0, 4'b1001, 4'b0000, 13'h0100, 0, 0, 13'h0100, 8'h00, 4'b1001, 4'b0000, 8'h00));
    tab.push_back(mkVec(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 8'h00, 4'b0000, 4'b1001, 8'h41));
    tab.push_back(mkVec(1, 4'b1111, 4'b0000, 13'h0000, 13'h0100, 13'h1FFF, 13'h0005, 8'h00, 4'b0000, 4'b0000, 8'h00));
    tab.push_back(mkVec(0, 4'b1111, 4'b0000, 13'h0000, 13'h0100, 13'h1FFF, 13'h0005, 8'h00, 4'b0011, 4'b0000, 8'h00));
    tab.push_back(mkVec(0, 4'b1111, 4'b0000, 13'h0000, 13'h0100, 13'h1FFF, 13'h0005, 8'h00, 4'b1100, 4'b0011, 8'h0E));
    tab.push_back(mkVec(0, 4'b1111, 4'b0000, 13'h0000, 13'h0100, 13'h1FFF, 13'h0005, 8'h00, 4'b0011, 4'b1100, 8'h10));
    tab.push_back(mkVec(1, 4'b1111, 4'b0000, 13'h0000, 13'h0100, 13'h1FFF, 13'h0005, 8'h00, 4'b0000, 4'b0000, 8'h00));
    tab.push_back(mkVec(0, 4'b0111, 4'b0000, 13'h0000, 13'h0100, 13'h1FFF, 13'h0005, 8'h00, 4'b0011, 4'b0000, 8'h00));
    tab.push_back(mkVec(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 8'h00, 4'b0000, 4'b0011, 8'h0E));

    @(posedge CLK);
    #1;
    for (int i = 0; i < tab.size(); i++) begin
      RST       = tab[i].rst;
      REQ_VALID = tab[i].valid;
      REQ_WE    = tab[i].we;
      REQ_ADDR  = tab[i].addr;
      REQ_WDATA = tab[i].wdata;
      applyStimulus(1, tab[i].expReady, tab[i].expRspV, tab[i].expRspD);
    end

    // Write/write hazard on one word: only one writer per cycle, the other waits its turn.
    RST = 1'b0;
    REQ_VALID = '0;
    setReq(0, 1, 1, 13'h0AAA, 2'b01);
    setReq(3, 1, 1, 13'h0AAA, 2'b10);
    applyStimulus(1, 4'b1000, 4'b0000, 8'h00);
    setReq(3, 0, 0, 13'h0000, 2'b00);
    applyStimulus(1, 4'b0001, 4'b0000, 8'h00);
    setReq(0, 0, 0, 13'h0000, 2'b00);
    setReq(1, 1, 0, 13'h0AAA, 2'b00);
    applyStimulus(1, 4'b0010, 4'b0000, 8'h00);
    setReq(1, 0, 0, 13'h0000, 2'b00);
    applyStimulus(1, 4'b0000, 4'b0010, 8'h04);

    // Same requester reading on consecutive cycles: responses arrive back to back, in order.
    setReq(2, 1, 0, 13'h0005, 2'b00);
    applyStimulus(1, 4'b0100, 4'b0000, 8'h00);
    setReq(2, 1, 0, 13'h1FFF, 2'b00);
    applyStimulus(1, 4'b0100, 4'b0100, 8'h20);
    setReq(2, 0, 0, 13'h0000, 2'b00);
    applyStimulus(1, 4'b0000, 4'b0100, 8'h30);

    // Random traffic over a small address set so hazards are frequent; requests hold until granted.
    for (int cyc = 0; cyc < 600; cyc++) begin
      RST = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < N; i++) begin
        if (!REQ_VALID[i] && ($urandom_range(0, 1) == 1)) begin
          sel = $urandom_range(0, 3);
          setReq(i, 1, 1'($urandom_range(0, 1)),
                 (sel == 0) ? 13'h0000 : (sel == 1) ? 13'h0001 :
                 (sel == 2) ? 13'h1FFF : 13'($urandom),
                 2'($urandom));
        end
      end
      applyStimulus(0, '0, '0, '0);
      REQ_VALID = REQ_VALID & ~lastGrant;
    end

    RST = 1'b0;
    REQ_VALID = '0;
    applyStimulus(0, '0, '0, '0);
    applyStimulus(0, '0, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
